// File: rtl/fanout_stim_pkg.sv
// Shared types and constants for the fanout stimulus generator.
package fanout_stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_TIE0 = 2'd0,
    MODE_TIE1 = 2'd1,
    MODE_LFSR = 2'd2,
    MODE_WALK = 2'd3
  } mode_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // An all-zero Galois LFSR never leaves zero, so substitute 1.
  function automatic logic [15:0] SAFE_SEED(input logic [15:0] s);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

endpackage

// File: rtl/fanout_lfsr.sv
// 16-bit right-shifting Galois LFSR with synchronous load and step enable.
module fanout_lfsr
  import fanout_stim_pkg::*;
#(
  parameter int          W     = 16,
  parameter int          OUT_W = 5,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  output logic [OUT_W-1:0] word_o,
  output logic [OUT_W-1:0] next_word_o
);

  logic [W-1:0] state_q;
  logic [W-1:0] state_d;
  logic [W-1:0] next_state;

  assign next_state = (state_q >> 1) ^ (state_q[0] ? W'(LFSR_TAPS) : W'(0));

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = W'(SAFE_SEED(SEED));
    end else if (step_i) begin
      state_d = next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= W'(SAFE_SEED(SEED));
    end else begin
      state_q <= state_d;
    end
  end

  assign word_o      = state_q[OUT_W-1:0];
  assign next_word_o = next_state[OUT_W-1:0];

endmodule

// File: rtl/fanout_stim_gen.sv
// Flop-driven broadcast source for a high-fanout load tree: bursts of
// tie-low, tie-high, LFSR or walking-one words under valid/ready handshake.
module fanout_stim_gen
  import fanout_stim_pkg::*;
#(
  parameter int          NUM_LOADS = 5,
  parameter int          LFSR_W    = 16,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [CNT_W-1:0]     burst_len,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_LOADS-1:0] out_data,
  output logic                 busy,
  output logic                 done
);

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [CNT_W-1:0]     len_q, len_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W:0]       cnt_inc;
  logic [NUM_LOADS-1:0] walk_q, walk_d;
  logic [NUM_LOADS-1:0] walk_rot;
  logic [NUM_LOADS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 lfsr_load;
  logic                 lfsr_step;
  logic [NUM_LOADS-1:0] lfsr_word;
  logic [NUM_LOADS-1:0] lfsr_next_word;
  logic                 xfer;

  function automatic logic [NUM_LOADS-1:0] rotl(input logic [NUM_LOADS-1:0] w);
    return (w << 1) | (w >> (NUM_LOADS - 1));
  endfunction

  function automatic logic [NUM_LOADS-1:0] pattern(input mode_e m,
                                                   input logic [NUM_LOADS-1:0] lw,
                                                   input logic [NUM_LOADS-1:0] ww);
    case (m)
      MODE_TIE0: return '0;
      MODE_TIE1: return '1;
      MODE_LFSR: return lw;
      MODE_WALK: return ww;
      default:   return '0;
    endcase
  endfunction

  fanout_lfsr #(
    .W     (LFSR_W),
    .OUT_W (NUM_LOADS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk         (clk),
    .rst         (rst),
    .load_i      (lfsr_load),
    .step_i      (lfsr_step),
    .word_o      (lfsr_word),
    .next_word_o (lfsr_next_word)
  );

  assign xfer     = valid_q & out_ready;
  assign cnt_inc  = {1'b0, cnt_q} + (CNT_W + 1)'(1);
  assign walk_rot = rotl(walk_q);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    walk_d    = walk_q;
    data_d    = data_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d    = mode_e'(mode);
          len_d     = burst_len;
          walk_d    = NUM_LOADS'(1);
          lfsr_load = 1'b1;
          busy_d    = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (len_q == '0) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          data_d  = pattern(mode_q, lfsr_word, walk_q);
          valid_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          cnt_d     = cnt_inc[CNT_W-1:0];
          lfsr_step = 1'b1;
          walk_d    = walk_rot;
          // Last transfer: drop valid on the same edge rather than emitting a stale word.
          if (cnt_inc == {1'b0, len_q}) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            data_d = pattern(mode_q, lfsr_next_word, walk_rot);
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_TIE0;
      len_q   <= '0;
      cnt_q   <= '0;
      walk_q  <= NUM_LOADS'(1);
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      walk_q  <= walk_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fanout_stim_gen.sv
// Bench for fanout_stim_gen: directed bursts plus randomized bursts against a word-sequence model.
module tb_fanout_stim_gen;

  localparam int          NL    = 5;
  localparam int          CW    = 8;
  localparam logic [15:0] TSEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [CW-1:0] burst_len;
  logic          out_valid;
  logic          out_ready;
  logic [NL-1:0] out_data;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fanout_stim_gen #(
    .NUM_LOADS (NL),
    .LFSR_W    (16),
    .SEED      (TSEED),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .burst_len (burst_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Word i of a burst, straight from the pattern definitions.
  function automatic logic [NL-1:0] exp_word(input int m, input int i);
    logic [15:0] s;
    s = (TSEED == 16'h0) ? 16'h0001 : TSEED;
    for (int k = 0; k < i; k++) s = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    case (m)
      0:       return '0;
      1:       return NL'((1 << NL) - 1);
      2:       return s[NL-1:0];
      default: return NL'(1 << (i % NL));
    endcase
  endfunction

  task automatic run_burst(input int m, input int len, input int pct, input int hold, input bit extra);
    int idx;
    int cyc;
    int budget;
    bit rdy;
    budget    = len * 40 + 20;
    mode      = m[1:0];
    burst_len = len[CW-1:0];
    start     = 1'b1;
    step();
    start     = 1'b0;
    mode      = 2'($urandom);
    burst_len = CW'($urandom);
    chk("busy_after_start", 32'(busy), 1);
    chk("valid_in_load", 32'(out_valid), 0);
    out_ready = 1'b0;
    step();
    if (len == 0) begin
      chk("zero_len_valid", 32'(out_valid), 0);
      chk("zero_len_done", 32'(done), 1);
      chk("zero_len_busy", 32'(busy), 1);
      step();
      chk("zero_len_done_clr", 32'(done), 0);
      chk("zero_len_busy_clr", 32'(busy), 0);
      chk("zero_len_valid2", 32'(out_valid), 0);
      return;
    end
    idx = 0;
    cyc = 0;
    while (idx < len && cyc < budget) begin
      chk("run_valid", 32'(out_valid), 1);
      chk($sformatf("word m%0d i%0d", m, idx), 32'(out_data), 32'(exp_word(m, idx)));
      chk("run_done_low", 32'(done), 0);
      rdy = (cyc < hold) ? 1'b0 : ($urandom_range(0, 99) < pct);
      out_ready = rdy;
      if (extra && $urandom_range(0, 2) == 0) start = 1'b1;
      step();
      start = 1'b0;
      if (rdy) idx++;
      cyc++;
    end
    out_ready = 1'b0;
    chk("transfers_done", 32'(idx), 32'(len));
    chk("end_valid", 32'(out_valid), 0);
    chk("end_done", 32'(done), 1);
    chk("end_busy", 32'(busy), 1);
    if (extra) start = 1'b1;
    step();
    start = 1'b0;
    chk("post_done_clr", 32'(done), 0);
    chk("post_busy_clr", 32'(busy), 0);
    chk("post_valid", 32'(out_valid), 0);
    step();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_valid", 32'(out_valid), 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    mode      = 2'd0;
    burst_len = '0;
    out_ready = 1'b0;
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    #10 rst = 1'b0;
    step();
    chk("idle_after_rst", 32'(busy), 0);

    run_burst(2, 3, 100, 0, 1'b0);
    run_burst(3, 7, 100, 0, 1'b0);
    run_burst(2, 2, 100, 4, 1'b0);
    run_burst(2, 0, 100, 0, 1'b0);

    // Reset in the middle of a six-word burst, between clock edges.
    mode      = 2'd2;
    burst_len = 8'd6;
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("mid_first_word", 32'(out_data), 32'(exp_word(2, 0)));
    step();
    step();
    chk("mid_third_word", 32'(out_data), 32'(exp_word(2, 2)));
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    #2 rst = 1'b0;
    out_ready = 1'b0;
    step();
    chk("mid_rst_no_done", 32'(done), 0);
    run_burst(2, 3, 100, 0, 1'b0);

    run_burst(1, 4, 100, 0, 1'b1);

    for (int r = 0; r < 12; r++) begin
      run_burst($urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(30, 100),
                $urandom_range(0, 3), 1'(r % 2));
    end

    run_burst(3, 255, 100, 0, 1'b0);
    run_burst(2, 255, 70, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fanout_stim_gen.md
Name: fanout_stim_gen

Overview:
Registered stimulus driver that sources the high-fanout broadcast net feeding the hierarchical load tree of a buffer-insertion test design, one bit per load branch.
- Sits directly upstream of the load hierarchy and replaces a constant tie-cell driver with a flop-driven net.
- Resizer buffer-insertion flows then see a real sequential driver, with timing arcs, on the net they split.

Parameters:
NUM_LOADS, 5, width of broadcast vector; one bit per downstream load branch; legal range 1..LFSR_W
LFSR_W, 16, LFSR state width; fixed at 16 for the tap constant
SEED, 16'hACE1, LFSR value loaded at start; a zero seed is replaced by 16'h0001
CNT_W, 8, width of burst length and transfer counter

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a burst; sampled only in IDLE
mode  input  2  0=tie-low, 1=tie-high, 2=LFSR, 3=walking-one; sampled at start
burst_len  input  CNT_W  number of transfers in the burst; sampled at start
out_valid  output  1  out_data holds a valid word
out_ready  input  1  downstream accepts word
out_data  output  NUM_LOADS  broadcast word to the load tree
busy  output  1  high from accepted start until DONE is exited
done  output  1  one-cycle pulse when the burst completes

Behaviour:
- Reset (async assert, sync release): state=IDLE, out_valid=0, out_data=0, busy=0, done=0, counter=0, LFSR=SEED.
- FSM states are IDLE, LOAD, RUN, DONE.
- IDLE, start=1: latch mode and burst_len, load LFSR=SEED (0 becomes 1), set walker=1, go to LOAD. busy=1 from the next cycle.
- IDLE, start=0: remain in IDLE.
- LOAD (one cycle):
  - If latched burst_len==0, go to DONE with no transfers.
  - Otherwise drive the first word, set out_valid=1, go to RUN.
  - Latency: first out_valid is asserted 2 cycles after start.
- RUN: a transfer occurs when out_valid and out_ready are both high at a clock edge.
  - On a transfer: counter+1, pattern advances, next word is registered.
  - While out_valid=1 and out_ready=0, out_data is held stable.
  - out_valid never drops mid-burst.
- RUN exit: on the transfer that makes counter==burst_len, clear out_valid and go to DONE in the same edge.
- DONE (one cycle): done=1, busy=0 on exit, counter cleared, return to IDLE.
- start is ignored in every state other than IDLE. start in the DONE cycle is dropped.
- out_data per mode:
  - 0: all zeros.
  - 1: all ones.
  - 2: LFSR[NUM_LOADS-1:0].
  - 3: walker.
- LFSR: Galois, right shift, taps 16'hB400. next = (s>>1) ^ (s[0] ? 16'hB400 : 0). Advances only on transfer.
- Walker: one-hot NUM_LOADS bits, rotates left on transfer; bit NUM_LOADS-1 wraps to bit0. NUM_LOADS=1 stays at 1.
- Counter is CNT_W bits with no wrap: burst_len max 2^CNT_W-1 terminates exactly.
- Reset asserted mid-burst: all outputs drop to reset values immediately (asynchronously). No partial done pulse.
- mode and burst_len changes after start have no effect until the next burst.
- out_data is driven straight from flops, with no combinational path from inputs to outputs. This keeps a clean single driver for the broadcast net.

Decomposition:
- Package fanout_stim_pkg holds:
  - state enum {IDLE, LOAD, RUN, DONE};
  - mode enum {MODE_TIE0, MODE_TIE1, MODE_LFSR, MODE_WALK};
  - LFSR_TAPS=16'hB400;
  - SAFE_SEED function (zero becomes 1).
- One sub-module, fanout_lfsr: 16-bit Galois LFSR with load, seed and step enable. FSM, counter, walker and output register stay in the top.

Test Plan:
- Reset, then mode=2, burst_len=3, out_ready=1, pulse start -> out_valid rises 2 cycles later; out_data = 5'h01, 5'h10, 5'h18 on consecutive cycles; done pulses once; busy falls.
- mode=3, NUM_LOADS=5, burst_len=7, out_ready=1 -> out_data = 01,02,04,08,10,01,02, then done.
- mode=2, burst_len=2, out_ready held low 4 cycles after the first valid -> out_data stays 5'h01 and out_valid stays 1 throughout; after ready=1, the second word is 5'h10.
- burst_len=0, start -> out_valid never asserts; done pulses in the cycle after LOAD; busy high for exactly 2 cycles.
- Mid-burst (after 2 of 6 transfers) assert rst between clock edges -> out_valid, out_data, busy, done all 0 before the next edge. A new start after release repeats from 5'h01.
- start pulsed during RUN, and mode=1 with burst_len=4 -> the extra start is ignored and exactly 4 transfers of 5'h1F occur.
